decodificador_binario_hexadecimal: RTL and testbench

//  - Converts a 4-bit binary nibble into the 7-segment pattern for its hex digit, 0-9 then A,b,C,d,E,F.
//  - Drives one 7-segment display on the FPGA board. Default polarity is common cathode (1 = segment lit).
//  - The output is registered so the segment lines are glitch-free and timed to the single system clock.

---
 rtl/decodificador_binario_hexadecimal.sv | 55 +++++
 tb/tb_decodificador_binario_hexadecimal.sv | 120 ++++++++++++
 2 files changed

// File: rtl/decodificador_binario_hexadecimal.sv
// Registered binary-to-hex 7-segment decoder for one board display.
// S[6:0] = {a,b,c,d,e,f,g}; COMMON_ANODE=1 inverts every segment bit.
module decodificador_binario_hexadecimal #(
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       blank,
  input  logic [3:0] A,
  output logic [6:0] S
);

  localparam logic [6:0] OFF = COMMON_ANODE ? 7'h7F : 7'h00;

  logic [6:0] seg_p0;

  // Glyph table is common cathode; lower-case b and d, tails on 6 and 9.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    unique case (nib)
      4'h0: pat = 7'h7E;
      4'h1: pat = 7'h30;
      4'h2: pat = 7'h6D;
      4'h3: pat = 7'h79;
      4'h4: pat = 7'h33;
      4'h5: pat = 7'h5B;
      4'h6: pat = 7'h5F;
      4'h7: pat = 7'h70;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h7B;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h1F;
      4'hC: pat = 7'h4E;
      4'hD: pat = 7'h3D;
      4'hE: pat = 7'h4F;
      4'hF: pat = 7'h47;
    endcase
    return COMMON_ANODE ? ~pat : pat;
  endfunction

  // Stage p0: the only register; reset and blank both force the dark pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_p0 <= OFF;
    end else if (blank) begin
      seg_p0 <= OFF;
    end else if (en) begin
      seg_p0 <= seg_decode(A);
    end
  end

  assign S = seg_p0;

endmodule

// File: tb/tb_decodificador_binario_hexadecimal.sv
// Directed bench: common-cathode and common-anode instances driven in parallel.
module tb_decodificador_binario_hexadecimal;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       blank;
  logic [3:0] A;
  logic [6:0] s_cc;
  logic [6:0] s_ca;

  int checks = 0;
  int errors = 0;

  logic [6:0] tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  decodificador_binario_hexadecimal #(.COMMON_ANODE(1'b0)) dut_cc (
    .clk(clk), .rst(rst), .en(en), .blank(blank), .A(A), .S(s_cc)
  );

  decodificador_binario_hexadecimal #(.COMMON_ANODE(1'b1)) dut_ca (
    .clk(clk), .rst(rst), .en(en), .blank(blank), .A(A), .S(s_ca)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    blank = 1'b0;
    A     = 4'h8;

    step();
    step();
    check_val("reset_cc", s_cc, 7'h00);
    check_val("reset_ca", s_ca, 7'h7F);

    rst = 1'b0;
    step();
    check_val("release_cc", s_cc, 7'h7F);
    check_val("release_ca", s_ca, 7'h00);

    for (int i = 0; i < 16; i++) begin
      A = 4'(i);
      step();
      check_val($sformatf("sweep_cc_%0h", i), s_cc, tbl[i]);
      check_val($sformatf("sweep_ca_%0h", i), s_ca, ~tbl[i]);
      repeat (9) step();
      check_val($sformatf("sweep_stable_cc_%0h", i), s_cc, tbl[i]);
    end

    // F -> 0 wrap
    A = 4'h0;
    step();
    check_val("wrap_cc", s_cc, 7'h7E);
    check_val("wrap_ca", s_ca, 7'h01);

    A = 4'h3;
    step();
    check_val("hold_capture", s_cc, 7'h79);
    en = 1'b0;
    A  = 4'hC;
    repeat (5) step();
    check_val("hold_cc", s_cc, 7'h79);
    check_val("hold_ca", s_ca, 7'h06);
    en = 1'b1;
    step();
    check_val("hold_release", s_cc, 7'h4E);

    A     = 4'h0;
    blank = 1'b1;
    step();
    check_val("blank_cc", s_cc, 7'h00);
    check_val("blank_ca", s_ca, 7'h7F);
    blank = 1'b0;
    step();
    check_val("unblank_cc", s_cc, 7'h7E);

    A = 4'h1;
    step();
    check_val("latency_first", s_cc, 7'h30);
    A = 4'h2;
    #1;
    check_val("latency_hold", s_cc, 7'h30);
    step();
    check_val("latency_next", s_cc, 7'h6D);

    // reset wins over enable
    rst = 1'b1;
    A   = 4'h9;
    step();
    check_val("reset_mid_cc", s_cc, 7'h00);
    check_val("reset_mid_ca", s_ca, 7'h7F);
    rst = 1'b0;
    en  = 1'b0;
    step();
    check_val("post_reset_idle", s_cc, 7'h00);
    en = 1'b1;
    step();
    check_val("post_reset_en", s_cc, 7'h7B);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
